// File: rtl/fc_mac_row.sv
// fc_mac_row: one fully-connected output row, y[c] = sum_r x[r] * W[r][c].
// Ports: clk/rst_i; start/busy run control; x_data/x_valid/x_ready activation stream;
//        w_en/w_addr/w_dout weight-row read (1-cycle registered); y_data/y_valid/y_ready result.
// Latency: DEPTH+2 cycles from start to y_valid with no x_valid gaps; y_data holds until consumed.
module fc_mac_row #(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 16,
  parameter  int COL        = 10,
  parameter  int ADDR_WIDTH = $clog2(DEPTH),
  localparam int ACC_WIDTH  = 2*WIDTH + ADDR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     start,
  output logic                     busy,
  input  logic [WIDTH-1:0]         x_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic                     w_en,
  output logic [ADDR_WIDTH-1:0]    w_addr,
  input  logic [WIDTH*COL-1:0]     w_dout,
  output logic [ACC_WIDTH*COL-1:0] y_data,
  output logic                     y_valid,
  input  logic                     y_ready
);

  localparam int PROD_WIDTH = 2*WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]         row_cnt;
  logic signed [WIDTH-1:0]       x_q;
  logic                          pipe_vld;
  logic                          accept;
  logic                          clear;
  logic signed [ACC_WIDTH-1:0]   acc  [COL];
  logic signed [PROD_WIDTH-1:0]  prod [COL];

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and control outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    x_ready   = 1'b0;
    w_en      = 1'b0;
    y_valid   = 1'b0;
    accept    = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        x_ready = 1'b1;
        if (x_valid) begin
          accept = 1'b1;
          w_en   = 1'b1;
          if (row_cnt == ADDR_WIDTH'(DEPTH-1)) state_nxt = DRAIN;
        end
      end
      // One idle cycle lets the last row's read data land and be accumulated.
      DRAIN: state_nxt = DONE;
      DONE: begin
        y_valid = 1'b1;
        if (y_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_addr = row_cnt;

  // Column c lives in the mirrored slice of the weight row.
  for (genvar c = 0; c < COL; c++) begin : g_col
    assign prod[c] = x_q * $signed(w_dout[(COL-1-c)*WIDTH +: WIDTH]);
    assign y_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[c];
  end

  // Datapath: x_q and pipe_vld line up the activation with the registered weight read.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      row_cnt  <= '0;
      x_q      <= '0;
      pipe_vld <= 1'b0;
      for (int c = 0; c < COL; c++) acc[c] <= '0;
    end else begin
      pipe_vld <= accept;
      if (accept) begin
        x_q     <= x_data;
        row_cnt <= row_cnt + ADDR_WIDTH'(1);
      end
      if (clear) begin
        row_cnt <= '0;
        for (int c = 0; c < COL; c++) acc[c] <= '0;
      end else if (pipe_vld) begin
        for (int c = 0; c < COL; c++)
          acc[c] <= acc[c] + {{EXT_WIDTH{prod[c][PROD_WIDTH-1]}}, prod[c]};
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_row.sv
module tb_fc_mac_row;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int COL   = 3;
  localparam int AW    = 2;
  localparam int ACCW  = 2*WIDTH + AW + 1;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  start;
  logic                  busy;
  logic [WIDTH-1:0]      x_data;
  logic                  x_valid;
  logic                  x_ready;
  logic                  w_en;
  logic [AW-1:0]         w_addr;
  logic [WIDTH*COL-1:0]  w_dout = '0;
  logic [ACCW*COL-1:0]   y_data;
  logic                  y_valid;
  logic                  y_ready;

  int wm [DEPTH][COL];
  int xv [DEPTH];
  int expv [COL];
  int n_cmp  = 0;
  int n_fail = 0;

  fc_mac_row #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COL(COL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_i(rst_i), .start(start), .busy(busy),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .w_en(w_en), .w_addr(w_addr), .w_dout(w_dout),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  // Behavioural weight buffer: 1-cycle registered read, column c at slice COL-1-c.
  always @(posedge clk) begin
    if (w_en) begin
      for (int c = 0; c < COL; c++)
        w_dout[(COL-1-c)*WIDTH +: WIDTH] <= WIDTH'(wm[w_addr][c]);
    end
  end

  // Reference: plain dot product per column.
  function automatic void calc_model();
    for (int c = 0; c < COL; c++) begin
      expv[c] = 0;
      for (int r = 0; r < DEPTH; r++) expv[c] += xv[r] * wm[r][c];
    end
  endfunction

  // Streams one run starting now (DUT in IDLE), then checks the result at the first y_valid.
  // gap: 0 = x_valid always high, 1 = low every other cycle, 2 = random.
  task automatic do_run(input string nm, input int gap, input int exp_lat);
    int idx = 0;
    int lat = -1;
    int got;
    calc_model();
    y_ready = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      start   = (cyc == 0);
      x_valid = (idx < DEPTH) &&
                (gap == 0 || (gap == 1 && cyc % 2 == 0) ||
                 (gap == 2 && $urandom_range(0, 1) == 1));
      x_data  = (idx < DEPTH) ? WIDTH'(xv[idx]) : '0;
      #1;
      if (y_valid) begin
        lat = cyc;
        break;
      end
      n_cmp++;
      if (x_valid && x_ready) begin
        if (w_en !== 1'b1 || w_addr !== AW'(idx)) begin
          n_fail++;
          $display("FAIL %s accept%0d: w_en=%b w_addr=%0d, required w_en=1 w_addr=%0d",
                   nm, idx, w_en, w_addr, idx);
        end
        idx++;
      end else if (w_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s w_en idle cyc%0d: got %b, required 0", nm, cyc, w_en);
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    x_valid = 1'b0;
    n_cmp++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL %s timeout: y_valid never rose, required within 100 cycles", nm);
    end else if (exp_lat >= 0 && lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, required %0d", nm, lat, exp_lat);
    end
    n_cmp++;
    if (idx != DEPTH) begin
      n_fail++;
      $display("FAIL %s accepts: got %0d, required %0d", nm, idx, DEPTH);
    end
    for (int c = 0; c < COL; c++) begin
      got = int'($signed(y_data[c*ACCW +: ACCW]));
      n_cmp++;
      if (got !== expv[c]) begin
        n_fail++;
        $display("FAIL %s y[%0d]: got %0d, required %0d", nm, c, got, expv[c]);
      end
    end
  endtask

  // Consumes the result: optional hold in DONE with stray start/x_valid, then handshake.
  task automatic handshake(input string nm, input int hold, input logic start_at_hs);
    int got;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      start   = (k == 1 || k == 3);
      x_valid = 1'b1;
      #1;
      n_cmp++;
      if (y_valid !== 1'b1 || busy !== 1'b1 || x_ready !== 1'b0 || w_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold%0d: y_valid=%b busy=%b x_ready=%b w_en=%b, required 1 1 0 0",
                 nm, k, y_valid, busy, x_ready, w_en);
      end
      for (int c = 0; c < COL; c++) begin
        got = int'($signed(y_data[c*ACCW +: ACCW]));
        n_cmp++;
        if (got !== expv[c]) begin
          n_fail++;
          $display("FAIL %s hold%0d y[%0d]: got %0d, required %0d", nm, k, c, got, expv[c]);
        end
      end
    end
    @(posedge clk); #1;
    x_valid = 1'b0;
    start   = start_at_hs;
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    start   = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after handshake: busy=%b y_valid=%b, required 0 0", nm, busy, y_valid);
    end
  endtask

  task automatic load_test1();
    for (int r = 0; r < DEPTH; r++) begin
      xv[r] = r + 1;
      for (int c = 0; c < COL; c++) wm[r][c] = r + c;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || y_valid !== 1'b0 || w_en !== 1'b0 || w_addr !== '0 ||
        x_ready !== 1'b0 || y_data !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b y_valid=%b w_en=%b w_addr=%0d x_ready=%b y_data=%h, required all 0",
               busy, y_valid, w_en, w_addr, x_ready, y_data);
    end
  endtask

  task automatic test_basic();
    load_test1();
    do_run("basic", 0, DEPTH + 2);
    handshake("basic", 0, 1'b0);
  endtask

  task automatic test_sign_width();
    for (int r = 0; r < DEPTH; r++) begin
      xv[r] = -128;
      for (int c = 0; c < COL; c++) wm[r][c] = -128;
    end
    do_run("neg_neg", 0, DEPTH + 2);
    handshake("neg_neg", 0, 1'b0);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COL; c++) wm[r][c] = 127;
    do_run("pos_neg", 0, DEPTH + 2);
    handshake("pos_neg", 0, 1'b0);
  endtask

  task automatic test_gaps();
    load_test1();
    do_run("gaps", 1, -1);
    handshake("gaps", 0, 1'b0);
  endtask

  task automatic test_hold();
    load_test1();
    do_run("hold", 0, DEPTH + 2);
    handshake("hold", 5, 1'b1);
    // start coincided with the handshake; it must not have launched a run.
    @(posedge clk); #2;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold start-at-handshake: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int accepts = 0;
    load_test1();
    start = 1'b1; x_valid = 1'b1; x_data = WIDTH'(xv[0]);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && accepts < 2; k++) begin
      x_data = WIDTH'(xv[accepts]);
      #1;
      if (x_ready) accepts++;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || y_valid !== 1'b0 || w_en !== 1'b0 || w_addr !== '0 || y_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b y_valid=%b w_en=%b w_addr=%0d y_data=%h, required all 0",
               busy, y_valid, w_en, w_addr, y_data);
    end
    do_run("mid_reset", 0, DEPTH + 2);
    handshake("mid_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_test1();
    do_run("b2b_first", 0, DEPTH + 2);
    handshake("b2b_first", 0, 1'b0);
    for (int r = 0; r < DEPTH; r++) xv[r] = 0;
    do_run("b2b_zero", 0, DEPTH + 2);
    handshake("b2b_zero", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < DEPTH; r++) begin
        xv[r] = $signed(8'($urandom));
        for (int c = 0; c < COL; c++) wm[r][c] = $signed(8'($urandom));
      end
      do_run("random", 2, -1);
      handshake("random", $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_width();
    test_gaps();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
